// File: rtl/uart_rx_packer.sv
// uart_rx_packer: requests bytes from the UART receiver and packs WORD_BYTES of them
// little-endian into a valid/ready word. UART_PACK_TIMEOUT_EN adds an inter-byte timeout.
module uart_rx_packer #(
    parameter int unsigned CLK_FREQ     = 20000000,
    parameter int unsigned BAUD_RATE    = 57600,
    parameter int unsigned BIT          = 8,
    parameter int unsigned WORD_BYTES   = 4,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [BIT-1:0]            byte_data,
    output logic                      byte_start,
    input  logic                      byte_ready,
    output logic [BIT*WORD_BYTES-1:0] word_data,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic                      err_timeout
);
    localparam int unsigned CYCLE          = CLK_FREQ / BAUD_RATE;
    localparam int unsigned TIMEOUT_CYCLES = CYCLE * TIMEOUT_BITS;
    localparam int unsigned WORD_W         = BIT * WORD_BYTES;
    localparam int unsigned IDX_W          = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    if (WORD_BYTES < 1 || WORD_BYTES > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("uart_rx_packer: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  byte_idx, byte_idx_n;
    logic [WORD_W-1:0] data_n;
    logic              start_n;
    logic              valid_n;

`ifdef UART_PACK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_n;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            byte_idx   <= '0;
            word_data  <= '0;
            byte_start <= 1'b0;
            word_valid <= 1'b0;
        end else begin
            state      <= state_n;
            byte_idx   <= byte_idx_n;
            word_data  <= data_n;
            byte_start <= start_n;
            word_valid <= valid_n;
        end
    end

`ifdef UART_PACK_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            err_timeout <= err_n;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        data_n     = word_data;
        start_n    = 1'b0;
        valid_n    = word_valid;
`ifdef UART_PACK_TIMEOUT_EN
        cnt_n      = '0;
        err_n      = 1'b0;
`endif
        unique case (state)
            S_REQ: begin
                // A still-high byte_ready means the receiver is not idle yet
                if (en && !byte_ready) begin
                    start_n = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (byte_ready) begin
                    data_n[BIT*32'(byte_idx) +: BIT] = byte_data;
                    if (byte_idx == IDX_W'(WORD_BYTES - 1)) begin
                        byte_idx_n = '0;
                        valid_n    = 1'b1;
                        state_n    = S_OUT;
                    end else begin
                        byte_idx_n = byte_idx + IDX_W'(1);
                        state_n    = S_REQ;
                    end
                end
`ifdef UART_PACK_TIMEOUT_EN
                // Request stays outstanding after a drop, so remain in S_WAIT
                else if (byte_idx != '0) begin
                    if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        byte_idx_n = '0;
                        err_n      = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
`endif
            end
            S_OUT: begin
                valid_n = 1'b1;
                if (word_valid && word_ready) begin
                    valid_n = 1'b0;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_packer.sv
// Self-checking bench for uart_rx_packer: a byte-level receiver model and a queue
// scoreboard of expected words, directed scenarios plus a randomized run.
module tb_uart_rx_packer;
    localparam int unsigned WB = 4;
    localparam int unsigned W  = 8 * WB;
    localparam int          TC = (20000000 / 57600) * 20;

    logic         clk = 1'b0;
    logic         rst, en, byte_start, rx_ready, force_ready, byte_ready;
    logic         word_valid, word_ready, err_timeout;
    logic [7:0]   byte_data;
    logic [W-1:0] word_data;

    assign byte_ready = rx_ready | force_ready;
    always #5 clk = ~clk;

    uart_rx_packer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .byte_data  (byte_data),
        .byte_start (byte_start),
        .byte_ready (byte_ready),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .err_timeout(err_timeout)
    );

    int           tests, fails;
    int           starts, words, errs, delivered;
    int           phase, rx_cnt;
    bit           prev_start, rx_stall;
    logic [7:0]   tx_q[$];
    logic [7:0]   acc_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: handshake for the coming edge, then receiver model at the falling edge
    task automatic tick();
        logic [W-1:0] w;
        bit           acc_now;
        acc_now = word_valid && word_ready;
        if (acc_now) begin
            words++;
            last_word = word_data;
            if (exp_q.size() == 0) check("word_unexpected", 64'(word_data), 64'(0));
            else begin
                w = exp_q.pop_front();
                check("word_data", 64'(word_data), 64'(w));
            end
        end
        @(negedge clk);
        if (acc_now) check("valid_drop", 64'(word_valid), 64'(0));
        if (err_timeout) errs++;
        if (byte_start) begin
            starts++;
            check("start_idle", 64'(byte_ready), 64'(0));
            check("start_single", 64'(prev_start), 64'(0));
            if (phase == 0) begin
                phase  = 1;
                rx_cnt = $urandom_range(6, 1);
            end
        end
        prev_start = byte_start;
        if (phase == 1 && !rx_stall) begin
            if (rx_cnt > 0) rx_cnt--;
            else begin
                if (tx_q.size() != 0) byte_data = tx_q.pop_front();
                else byte_data = 8'($urandom);
                rx_ready = 1'b1;
                delivered++;
                acc_q.push_back(byte_data);
                if (acc_q.size() == WB) begin
                    w = '0;
                    for (int i = 0; i < WB; i++) w = w | (W'(acc_q[i]) << (8 * i));
                    exp_q.push_back(w);
                    acc_q.delete();
                end
                phase  = 2;
                rx_cnt = $urandom_range(3, 0);
            end
        end else if (phase == 2) begin
            if (rx_cnt > 0) rx_cnt--;
            else begin
                rx_ready = 1'b0;
                phase    = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_start", 64'(byte_start), 64'(0));
        check("rst_valid", 64'(word_valid), 64'(0));
        check("rst_err", 64'(err_timeout), 64'(0));
        check("rst_data", 64'(word_data), 64'(0));
        phase = 0; rx_ready = 1'b0; rx_stall = 1'b0; prev_start = 1'b0;
        tx_q.delete(); acc_q.delete(); exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int target, k;
        target = words + n;
        k = 0;
        while (words < target && k < budget) begin tick(); k++; end
        check(tag, 64'(words), 64'(target));
    endtask

    task automatic wait_delivered(input int n, input int budget, input string tag);
        int target, k;
        target = delivered + n;
        k = 0;
        while (delivered < target && k < budget) begin tick(); k++; end
        check(tag, 64'(delivered), 64'(target));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           s0, bad, n, e0, w0;
        logic [W-1:0] exp_w;
        tests = 0; fails = 0; starts = 0; words = 0; errs = 0; delivered = 0;
        rst = 1'b0; en = 1'b0; word_ready = 1'b0; force_ready = 1'b0;
        rx_ready = 1'b0; byte_data = 8'h00; rx_stall = 1'b0; phase = 0; rx_cnt = 0;
        prev_start = 1'b0; last_word = '0;

        // Basic word, downstream always ready
        do_reset();
        en = 1'b1; word_ready = 1'b1; starts = 0;
        tx_q = {8'h11, 8'h22, 8'h33, 8'h44};
        wait_words(1, 300, "wait_word1");
        check("starts_per_word", 64'(starts), 64'(4));
        check("word1", 64'(last_word), 64'(32'h4433_2211));

        // Downstream stall then release
        do_reset();
        en = 1'b1; word_ready = 1'b0;
        for (int i = 0; i < 300 && !word_valid; i++) tick();
        check("stall_valid_rise", 64'(word_valid), 64'(1));
        check("stall_have_exp", 64'(exp_q.size()), 64'(1));
        exp_w = (exp_q.size() != 0) ? exp_q[0] : '0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!word_valid || word_data !== exp_w || byte_start) bad++;
        end
        check("stall_hold", 64'(bad), 64'(0));
        word_ready = 1'b1;
        tick();
        check("release_nostart", 64'(byte_start), 64'(0));
        tick();
        check("release_start", 64'(byte_start), 64'(1));

        // byte_ready high out of reset blocks requests
        force_ready = 1'b1;
        do_reset();
        en = 1'b1; s0 = starts;
        repeat (10) tick();
        check("forced_nostart", 64'(starts - s0), 64'(0));
        force_ready = 1'b0;
        tick();
        check("start_after_drop", 64'(byte_start), 64'(1));

        // en pause keeps the partial word
        do_reset();
        en = 1'b1; word_ready = 1'b1;
        tx_q = {8'hAA, 8'hBB};
        wait_delivered(2, 100, "wait_two_bytes");
        en = 1'b0; s0 = starts;
        repeat (100) tick();
        check("en_pause", 64'(starts - s0), 64'(0));
        tx_q = {8'hCC, 8'hDD};
        en = 1'b1;
        wait_words(1, 300, "wait_word_en");
        check("word_en", 64'(last_word), 64'(32'hDDCC_BBAA));

`ifdef UART_PACK_TIMEOUT_EN
        // Silence after one byte drops the partial word
        do_reset();
        en = 1'b1; word_ready = 1'b1;
        tx_q = {8'h5A};
        wait_delivered(1, 100, "wait_timeout_byte");
        rx_stall = 1'b1; e0 = errs; n = 0;
        while (errs == e0 && n < TC + 100) begin tick(); n++; end
        check("timeout_fired", 64'(errs - e0), 64'(1));
        check("timeout_window", 64'(n >= TC + 2 && n <= TC + 5), 64'(1));
        repeat (20) tick();
        check("timeout_single", 64'(errs - e0), 64'(1));
        acc_q.delete();
        tx_q = {8'h01, 8'h02, 8'h03, 8'h04};
        rx_stall = 1'b0;
        wait_words(1, 300, "wait_word_after_timeout");
        check("word_after_timeout", 64'(last_word), 64'(32'h0403_0201));
`endif

        // Reset mid-word discards the partial word
        do_reset();
        en = 1'b1; word_ready = 1'b1;
        tx_q = {8'hC1, 8'hC2, 8'hC3};
        wait_delivered(3, 100, "wait_three_bytes");
        tick(); tick();
        do_reset();
        tx_q = {8'hD1, 8'hD2, 8'hD3, 8'hD4};
        wait_words(1, 300, "wait_word_fresh");
        check("word_fresh", 64'(last_word), 64'(32'hD4D3_D2D1));

        // Randomized traffic with random enable and backpressure
        do_reset();
        w0 = words;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(9, 0) != 0);
            word_ready = ($urandom_range(3, 0) != 0);
            if (tx_q.size() < 4) tx_q.push_back(8'($urandom));
            tick();
        end
        en = 1'b0; word_ready = 1'b1;
        repeat (200) tick();
        check("random_drain", 64'(exp_q.size()), 64'(0));
        check("random_words", 64'((words - w0) > 20), 64'(1));

`ifdef UART_PACK_TIMEOUT_EN
        check("err_total", 64'(errs), 64'(1));
`else
        check("err_total", 64'(errs), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
